// File: rtl/rx_packet_buffer_sched_if.sv
// Bundles the decoder write strobes, processor read strobes, FIFO-bank
// controls and status outputs of the RX packet buffer scheduler.
interface rx_packet_buffer_sched_if #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned PTR_W     = 2
);
  logic                 wr_sop;
  logic                 wr_valid;
  logic                 wr_eop;
  logic                 wr_abort;
  logic                 rd_req;
  logic                 rd_pkt_done;
  logic [NUM_FIFOS-1:0] rx_fifo_empty;
  logic [NUM_FIFOS-1:0] irx_fifo_wr_en;
  logic [NUM_FIFOS-1:0] irx_fifo_rd_en;
  logic [NUM_FIFOS-1:0] fifo_flush;
  logic [PTR_W-1:0]     readfifo_write_ptr;
  logic [PTR_W-1:0]     readfifo_read_ptr;
  logic [7:0]           rx_packet_depth;
  logic                 rx_packet_avail;
  logic                 rx_fifo_overflow;
  logic                 rx_fifo_underrun;
  logic                 rx_pkt_discard;

  // Decoder/processor/bank side: drives strobes and empty flags.
  modport master (
    output wr_sop, wr_valid, wr_eop, wr_abort, rd_req, rd_pkt_done, rx_fifo_empty,
    input  irx_fifo_wr_en, irx_fifo_rd_en, fifo_flush, readfifo_write_ptr,
           readfifo_read_ptr, rx_packet_depth, rx_packet_avail, rx_fifo_overflow,
           rx_fifo_underrun, rx_pkt_discard
  );

  // Scheduler side.
  modport slave (
    input  wr_sop, wr_valid, wr_eop, wr_abort, rd_req, rd_pkt_done, rx_fifo_empty,
    output irx_fifo_wr_en, irx_fifo_rd_en, fifo_flush, readfifo_write_ptr,
           readfifo_read_ptr, rx_packet_depth, rx_packet_avail, rx_fifo_overflow,
           rx_fifo_underrun, rx_pkt_discard
  );
endinterface

// File: rtl/rx_packet_buffer_sched.sv
// RX packet buffer scheduler: steers each decoded packet into one whole FIFO
// of the bank, hands committed packets to the processor in order, tracks the
// committed-packet count and flushes aborted or released buffers.
module rx_packet_buffer_sched #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned PTR_W     = 2
) (
  input logic                     clk16x,
  input logic                     reset_n,
  rx_packet_buffer_sched_if.slave bus
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(NUM_FIFOS);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;

  wstate_t              state, state_nxt;
  logic [PTR_W-1:0]     write_ptr, read_ptr;
  logic [PTR_W:0]       count;
  logic                 count_nz;
  logic                 commit, wr_flush, overflow_nxt;
  logic                 rd_ok, underrun_nxt, release_pkt;
  logic [NUM_FIFOS-1:0] wr_en, rd_en, flush_nxt;
  logic [NUM_FIFOS-1:0] flush_q;
  logic                 discard_q, overflow_q, underrun_q, avail_q;
  logic [7:0]           depth_q;

  assign count_nz = (count != '0);

  // Write FSM next state, combinational write enable and commit/flush decode.
  always_comb begin
    state_nxt    = state;
    wr_en        = '0;
    commit       = 1'b0;
    wr_flush     = 1'b0;
    overflow_nxt = 1'b0;
    case (state)
      W_IDLE: begin
        if (bus.wr_sop) begin
          if (count == FULL) begin
            state_nxt    = W_DROP;
            overflow_nxt = 1'b1;
          end else begin
            state_nxt = W_FILL;
          end
        end
      end
      W_FILL: begin
        wr_en[write_ptr] = bus.wr_valid;
        if (bus.wr_abort) begin
          wr_flush  = 1'b1;
          state_nxt = W_IDLE;
        end else if (bus.wr_eop) begin
          commit    = 1'b1;
          state_nxt = W_IDLE;
        end else if (bus.wr_sop) begin
          // Missing eop: discard the partial packet, restart in the same FIFO.
          wr_flush = 1'b1;
        end
      end
      W_DROP: begin
        if (bus.wr_eop || bus.wr_abort) state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  // Read-side enable, underrun/release decode and merged flush vector.
  always_comb begin
    rd_en = '0;
    rd_ok = count_nz & ~bus.rx_fifo_empty[read_ptr];
    if (bus.rd_req && rd_ok) rd_en[read_ptr] = 1'b1;
    underrun_nxt = bus.rd_req & ~rd_ok;
    release_pkt  = bus.rd_pkt_done & count_nz;
    flush_nxt = '0;
    if (wr_flush)    flush_nxt[write_ptr] = 1'b1;
    if (release_pkt) flush_nxt[read_ptr]  = 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge clk16x or negedge reset_n) begin
    if (!reset_n) state <= W_IDLE;
    else          state <= state_nxt;
  end

  // Buffer pointers and committed-packet count.
  always_ff @(posedge clk16x or negedge reset_n) begin
    if (!reset_n) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else begin
      if (commit)      write_ptr <= write_ptr + 1'b1;
      if (release_pkt) read_ptr  <= read_ptr + 1'b1;
      case ({commit, release_pkt})
        2'b10:   if (count != FULL) count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered status pulses and depth/availability.
  always_ff @(posedge clk16x or negedge reset_n) begin
    if (!reset_n) begin
      flush_q    <= '0;
      discard_q  <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      depth_q    <= '0;
      avail_q    <= 1'b0;
    end else begin
      flush_q    <= flush_nxt;
      discard_q  <= wr_flush;
      overflow_q <= overflow_nxt;
      underrun_q <= underrun_nxt;
      depth_q    <= 8'(count);
      avail_q    <= count_nz;
    end
  end

  assign bus.irx_fifo_wr_en     = wr_en;
  assign bus.irx_fifo_rd_en     = rd_en;
  assign bus.fifo_flush         = flush_q;
  assign bus.readfifo_write_ptr = write_ptr;
  assign bus.readfifo_read_ptr  = read_ptr;
  assign bus.rx_packet_depth    = depth_q;
  assign bus.rx_packet_avail    = avail_q;
  assign bus.rx_fifo_overflow   = overflow_q;
  assign bus.rx_fifo_underrun   = underrun_q;
  assign bus.rx_pkt_discard     = discard_q;
endmodule

// File: tb/tb_rx_packet_buffer_sched.sv
// Bench for rx_packet_buffer_sched: directed scenarios plus a randomized run
// checked against a queue-based packet model.
module tb_rx_packet_buffer_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2;

  logic clk16x  = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk16x = ~clk16x;

  rx_packet_buffer_sched_if #(.NUM_FIFOS(N), .PTR_W(PW)) bus ();
  rx_packet_buffer_sched #(.NUM_FIFOS(N), .PTR_W(PW)) dut (
    .clk16x (clk16x),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: queue of committed buffer indices, oldest first.
  int   q[$];
  int   rp;
  bit   filling, dropping;
  logic [3:0] e_wr_en, e_rd_en, e_flush;
  logic       e_disc, e_ovf, e_und, e_avail;
  logic [7:0] e_depth;

  function automatic int wbuf();
    return (rp + q.size()) % N;
  endfunction

  task automatic model_reset();
    q.delete();
    rp = 0; filling = 0; dropping = 0;
    e_flush = '0; e_disc = 0; e_ovf = 0; e_und = 0; e_depth = '0; e_avail = 0;
    e_wr_en = '0; e_rd_en = '0;
  endtask

  // Applied at each rising edge, using the inputs held during the cycle.
  task automatic model_update();
    int  cnt = q.size();
    int  wb  = wbuf();
    bit  readable = (cnt > 0) && !bus.rx_fifo_empty[rp];
    bit  commit = 0;
    logic [3:0] fl = '0;
    e_disc = 0; e_ovf = 0;
    e_und  = bus.rd_req && !readable;
    if (filling) begin
      if (bus.wr_abort)    begin fl[wb] = 1'b1; e_disc = 1; filling = 0; end
      else if (bus.wr_eop) begin commit = 1; filling = 0; end
      else if (bus.wr_sop) begin fl[wb] = 1'b1; e_disc = 1; end
    end else if (dropping) begin
      if (bus.wr_eop || bus.wr_abort) dropping = 0;
    end else if (bus.wr_sop) begin
      if (cnt == N) begin dropping = 1; e_ovf = 1; end
      else filling = 1;
    end
    e_depth = 8'(cnt);
    e_avail = (cnt != 0);
    if (bus.rd_pkt_done && cnt > 0) begin
      fl[rp] = 1'b1;
      void'(q.pop_front());
      rp = (rp + 1) % N;
    end
    if (commit) q.push_back(wb);
    e_flush = fl;
  endtask

  // Called just after a rising edge; leaves time at the following falling edge.
  task automatic drive(input bit sop, valid, eop, abort, rq, done, input logic [3:0] empty);
    bus.wr_sop = sop; bus.wr_valid = valid; bus.wr_eop = eop; bus.wr_abort = abort;
    bus.rd_req = rq; bus.rd_pkt_done = done; bus.rx_fifo_empty = empty;
    e_wr_en = (filling && valid) ? (4'b0001 << wbuf()) : 4'b0000;
    e_rd_en = (rq && q.size() > 0 && !empty[rp]) ? (4'b0001 << rp) : 4'b0000;
    @(negedge clk16x);
  endtask

  task automatic tick();
    @(posedge clk16x);
    #1;
    model_update();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    tick();
  endtask

  task automatic send_pkt(input int nbytes);
    drive(1, 0, 0, 0, 0, 0, 4'b0000); tick();
    repeat (nbytes) begin drive(0, 1, 0, 0, 0, 0, 4'b0000); tick(); end
    drive(0, 0, 1, 0, 0, 0, 4'b0000); tick();
  endtask

  task automatic test_reset();
    bus.wr_sop = 0; bus.wr_valid = 0; bus.wr_eop = 0; bus.wr_abort = 0;
    bus.rd_req = 0; bus.rd_pkt_done = 0; bus.rx_fifo_empty = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk16x);
    @(negedge clk16x);
    n_checks++; if (bus.readfifo_write_ptr !== 2'd0) $display("FAIL reset_wp got %0d want 0", bus.readfifo_write_ptr); else n_pass++;
    n_checks++; if (bus.readfifo_read_ptr !== 2'd0) $display("FAIL reset_rp got %0d want 0", bus.readfifo_read_ptr); else n_pass++;
    n_checks++; if (bus.rx_packet_depth !== 8'd0) $display("FAIL reset_depth got %0d want 0", bus.rx_packet_depth); else n_pass++;
    n_checks++; if ({bus.rx_packet_avail, bus.rx_fifo_overflow, bus.rx_fifo_underrun, bus.rx_pkt_discard, bus.fifo_flush} !== 8'd0)
      $display("FAIL reset_flags got %b want 0", {bus.rx_packet_avail, bus.rx_fifo_overflow, bus.rx_fifo_underrun, bus.rx_pkt_discard, bus.fifo_flush});
    else n_pass++;
    @(posedge clk16x); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_commit();
    drive(1, 0, 0, 0, 0, 0, 4'b0000); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 0, 4'b0000);
      n_checks++; if (bus.irx_fifo_wr_en !== 4'b0001) $display("FAIL commit_wr_en byte %0d got %b want 0001", i, bus.irx_fifo_wr_en); else n_pass++;
      tick();
    end
    drive(0, 0, 1, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.irx_fifo_wr_en !== 4'b0000) $display("FAIL commit_eop_wr_en got %b want 0000", bus.irx_fifo_wr_en); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.readfifo_write_ptr !== 2'd1) $display("FAIL commit_wp got %0d want 1", bus.readfifo_write_ptr); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_packet_depth !== 8'd1) $display("FAIL commit_depth got %0d want 1", bus.rx_packet_depth); else n_pass++;
    n_checks++; if (bus.rx_packet_avail !== 1'b1) $display("FAIL commit_avail got %b want 1", bus.rx_packet_avail); else n_pass++;
    tick();
  endtask

  task automatic test_overflow();
    repeat (3) send_pkt(2);
    drive(1, 0, 0, 0, 0, 0, 4'b0000); tick();
    drive(0, 1, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_fifo_overflow !== 1'b1) $display("FAIL ovf_pulse got %b want 1", bus.rx_fifo_overflow); else n_pass++;
    n_checks++; if (bus.irx_fifo_wr_en !== 4'b0000) $display("FAIL ovf_wr_en0 got %b want 0000", bus.irx_fifo_wr_en); else n_pass++;
    tick();
    drive(0, 1, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_fifo_overflow !== 1'b0) $display("FAIL ovf_pulse_end got %b want 0", bus.rx_fifo_overflow); else n_pass++;
    n_checks++; if (bus.irx_fifo_wr_en !== 4'b0000) $display("FAIL ovf_wr_en1 got %b want 0000", bus.irx_fifo_wr_en); else n_pass++;
    tick();
    drive(0, 1, 1, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.irx_fifo_wr_en !== 4'b0000) $display("FAIL ovf_wr_en_eop got %b want 0000", bus.irx_fifo_wr_en); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_packet_depth !== 8'd4) $display("FAIL ovf_depth got %0d want 4", bus.rx_packet_depth); else n_pass++;
    n_checks++; if (bus.readfifo_write_ptr !== 2'd0) $display("FAIL ovf_wp got %0d want 0", bus.readfifo_write_ptr); else n_pass++;
    tick();
    repeat (4) begin drive(0, 0, 0, 0, 0, 1, 4'b0000); tick(); end
    idle();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_packet_depth !== 8'd0) $display("FAIL drain_depth got %0d want 0", bus.rx_packet_depth); else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    drive(1, 0, 0, 0, 0, 0, 4'b0000); tick();
    repeat (3) begin drive(0, 1, 0, 0, 0, 0, 4'b0000); tick(); end
    drive(0, 0, 0, 1, 0, 0, 4'b0000); tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.fifo_flush !== 4'b0001) $display("FAIL abort_flush got %b want 0001", bus.fifo_flush); else n_pass++;
    n_checks++; if (bus.rx_pkt_discard !== 1'b1) $display("FAIL abort_discard got %b want 1", bus.rx_pkt_discard); else n_pass++;
    n_checks++; if (bus.readfifo_write_ptr !== 2'd0) $display("FAIL abort_wp got %0d want 0", bus.readfifo_write_ptr); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.fifo_flush !== 4'b0000) $display("FAIL abort_flush_end got %b want 0000", bus.fifo_flush); else n_pass++;
    n_checks++; if (bus.rx_packet_depth !== 8'd0) $display("FAIL abort_depth got %0d want 0", bus.rx_packet_depth); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    send_pkt(1); send_pkt(1);
    idle();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_packet_depth !== 8'd2) $display("FAIL b2b_depth_pre got %0d want 2", bus.rx_packet_depth); else n_pass++;
    tick();
    drive(1, 0, 0, 0, 0, 0, 4'b0000); tick();
    drive(0, 1, 0, 0, 0, 0, 4'b0000); tick();
    drive(0, 0, 1, 0, 0, 1, 4'b0000); tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.readfifo_read_ptr !== 2'd1) $display("FAIL b2b_rp got %0d want 1", bus.readfifo_read_ptr); else n_pass++;
    n_checks++; if (bus.readfifo_write_ptr !== 2'd3) $display("FAIL b2b_wp got %0d want 3", bus.readfifo_write_ptr); else n_pass++;
    n_checks++; if (bus.fifo_flush !== 4'b0001) $display("FAIL b2b_flush got %b want 0001", bus.fifo_flush); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_packet_depth !== 8'd2) $display("FAIL b2b_depth got %0d want 2", bus.rx_packet_depth); else n_pass++;
    tick();
  endtask

  task automatic test_underrun();
    repeat (2) begin drive(0, 0, 0, 0, 0, 1, 4'b0000); tick(); end
    idle(); idle();
    drive(0, 0, 0, 0, 1, 0, 4'b0000);
    n_checks++; if (bus.irx_fifo_rd_en !== 4'b0000) $display("FAIL und_rd_en got %b want 0000", bus.irx_fifo_rd_en); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_fifo_underrun !== 1'b1) $display("FAIL und_pulse got %b want 1", bus.rx_fifo_underrun); else n_pass++;
    n_checks++; if (bus.rx_packet_depth !== 8'd0) $display("FAIL und_depth got %0d want 0", bus.rx_packet_depth); else n_pass++;
    n_checks++; if (bus.readfifo_read_ptr !== 2'd3) $display("FAIL und_rp got %0d want 3", bus.readfifo_read_ptr); else n_pass++;
    n_checks++; if (bus.readfifo_write_ptr !== 2'd3) $display("FAIL und_wp got %0d want 3", bus.readfifo_write_ptr); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_fifo_underrun !== 1'b0) $display("FAIL und_pulse_end got %b want 0", bus.rx_fifo_underrun); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midpacket();
    drive(1, 0, 0, 0, 0, 0, 4'b0000); tick();
    repeat (2) begin drive(0, 1, 0, 0, 0, 0, 4'b0000); tick(); end
    bus.wr_sop = 0; bus.wr_valid = 0; bus.wr_eop = 0; bus.wr_abort = 0;
    bus.rd_req = 0; bus.rd_pkt_done = 0; bus.rx_fifo_empty = '0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk16x);
    n_checks++; if ({bus.irx_fifo_wr_en, bus.irx_fifo_rd_en, bus.fifo_flush, bus.readfifo_write_ptr, bus.readfifo_read_ptr} !== 16'd0)
      $display("FAIL rstmid_vec got %h want 0", {bus.irx_fifo_wr_en, bus.irx_fifo_rd_en, bus.fifo_flush, bus.readfifo_write_ptr, bus.readfifo_read_ptr});
    else n_pass++;
    n_checks++; if ({bus.rx_packet_depth, bus.rx_packet_avail, bus.rx_fifo_overflow, bus.rx_fifo_underrun, bus.rx_pkt_discard} !== 12'd0)
      $display("FAIL rstmid_status got %h want 0", {bus.rx_packet_depth, bus.rx_packet_avail, bus.rx_fifo_overflow, bus.rx_fifo_underrun, bus.rx_pkt_discard});
    else n_pass++;
    @(posedge clk16x); #1;
    reset_n = 1'b1;
    drive(0, 1, 1, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.irx_fifo_wr_en !== 4'b0000) $display("FAIL rstmid_eop_wr_en got %b want 0000", bus.irx_fifo_wr_en); else n_pass++;
    tick();
    drive(0, 1, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.irx_fifo_wr_en !== 4'b0000) $display("FAIL rstmid_wr_en got %b want 0000", bus.irx_fifo_wr_en); else n_pass++;
    n_checks++; if (bus.rx_pkt_discard !== 1'b0) $display("FAIL rstmid_discard got %b want 0", bus.rx_pkt_discard); else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    n_checks++; if (bus.rx_packet_depth !== 8'd0) $display("FAIL rstmid_depth got %0d want 0", bus.rx_packet_depth); else n_pass++;
    n_checks++; if (bus.readfifo_write_ptr !== 2'd0) $display("FAIL rstmid_wp got %0d want 0", bus.readfifo_write_ptr); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] emp;
      for (int b = 0; b < N; b++) emp[b] = ($urandom_range(99) < 20);
      drive($urandom_range(99) < 8, $urandom_range(99) < 60, $urandom_range(99) < 10,
            $urandom_range(99) < 3, $urandom_range(99) < 30, $urandom_range(99) < 8, emp);
      n_checks++; if (bus.irx_fifo_wr_en !== e_wr_en) $display("FAIL rnd_wr_en cyc %0d got %b want %b", c, bus.irx_fifo_wr_en, e_wr_en); else n_pass++;
      n_checks++; if (bus.irx_fifo_rd_en !== e_rd_en) $display("FAIL rnd_rd_en cyc %0d got %b want %b", c, bus.irx_fifo_rd_en, e_rd_en); else n_pass++;
      n_checks++; if (bus.fifo_flush !== e_flush) $display("FAIL rnd_flush cyc %0d got %b want %b", c, bus.fifo_flush, e_flush); else n_pass++;
      n_checks++; if (bus.rx_pkt_discard !== e_disc) $display("FAIL rnd_discard cyc %0d got %b want %b", c, bus.rx_pkt_discard, e_disc); else n_pass++;
      n_checks++; if (bus.rx_fifo_overflow !== e_ovf) $display("FAIL rnd_overflow cyc %0d got %b want %b", c, bus.rx_fifo_overflow, e_ovf); else n_pass++;
      n_checks++; if (bus.rx_fifo_underrun !== e_und) $display("FAIL rnd_underrun cyc %0d got %b want %b", c, bus.rx_fifo_underrun, e_und); else n_pass++;
      n_checks++; if (bus.rx_packet_depth !== e_depth) $display("FAIL rnd_depth cyc %0d got %0d want %0d", c, bus.rx_packet_depth, e_depth); else n_pass++;
      n_checks++; if (bus.rx_packet_avail !== e_avail) $display("FAIL rnd_avail cyc %0d got %b want %b", c, bus.rx_packet_avail, e_avail); else n_pass++;
      n_checks++; if (bus.readfifo_write_ptr !== PW'(wbuf())) $display("FAIL rnd_wp cyc %0d got %0d want %0d", c, bus.readfifo_write_ptr, wbuf()); else n_pass++;
      n_checks++; if (bus.readfifo_read_ptr !== PW'(rp)) $display("FAIL rnd_rp cyc %0d got %0d want %0d", c, bus.readfifo_read_ptr, rp); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_underrun();
    test_reset_midpacket();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
